// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encodings, parity mode codes and
// default oversampling rate, used by both the transmitter and the receiver.
package uart_pkg;

  localparam int N_STATES        = 5;
  localparam int N_TICKS_DEFAULT = 16;
  localparam int NB_DATA_MIN     = 5;

  localparam logic [N_STATES-1:0] ST_IDLE   = 5'b00001;
  localparam logic [N_STATES-1:0] ST_START  = 5'b00010;
  localparam logic [N_STATES-1:0] ST_DATA   = 5'b00100;
  localparam logic [N_STATES-1:0] ST_PARITY = 5'b01000;
  localparam logic [N_STATES-1:0] ST_STOP   = 5'b10000;

  // Code 2'b11 is not listed; both ends treat it as PAR_NONE.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

endpackage

// File: rtl/uart_parity_gen.sv
// Masked parity of the low nb_data bits of a word; odd=1 inverts the result.
// Shared by the transmitter (generation) and the receiver (checking).
module uart_parity_gen #(
  parameter int NB_DATA = 8
) (
  input  logic [NB_DATA-1:0] data,
  input  logic [3:0]         nb_data,
  input  logic               odd,
  output logic               parity
);

  always_comb begin
    // NOTE: combinational logic uses blocking assignments, and the output gets a
    // default before the loop so every path assigns it and no latch is inferred.
    parity = odd;
    for (int i = 0; i < NB_DATA; i++) begin
      if (i < int'(nb_data)) parity = parity ^ data[i];
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter (5..NB_DATA_MAX data bits, N/E/O parity,
// 1 or 2 stop bits). Define UART_TX_BREAK_EN to add the line-break request.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA_MAX     = 8,
  parameter int N_TICKS         = N_TICKS_DEFAULT,
  parameter int NB_TICK_COUNTER = $clog2(N_TICKS),
  parameter int NB_BIT_COUNTER  = $clog2(NB_DATA_MAX)
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_tick,
  input  logic [NB_DATA_MAX-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [3:0]             i_nb_data,
  input  logic [1:0]             i_parity,
  input  logic                   i_stop2,
  input  logic                   i_break,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  logic [N_STATES-1:0]        state;
  logic [NB_TICK_COUNTER-1:0] tick_cnt;
  logic [NB_BIT_COUNTER-1:0]  bit_cnt;
  logic [NB_BIT_COUNTER-1:0]  last_bit;
  logic [NB_DATA_MAX-1:0]     shift_reg;
  logic                       par_en;
  logic                       par_bit;
  logic                       stop2;
  logic                       tx_q;

  logic [3:0] nb_clamped;
  logic [3:0] nb_last;
  logic       par_calc;
  logic       break_req;
  logic       idle;
  logic       transfer;
  logic       tick_end;
  logic       stop_end;

  assign nb_clamped = (i_nb_data < 4'(NB_DATA_MIN) || i_nb_data > 4'(NB_DATA_MAX))
                      ? 4'(NB_DATA_MAX) : i_nb_data;
  assign nb_last    = nb_clamped - 4'd1;

  // Parity is resolved at accept time from the live inputs, so the shift
  // register is free to consume the word during the data phase.
  uart_parity_gen #(
    .NB_DATA (NB_DATA_MAX)
  ) u_parity (
    .data    (i_data),
    .nb_data (nb_clamped),
    .odd     (i_parity == PAR_ODD),
    .parity  (par_calc)
  );

`ifdef UART_TX_BREAK_EN
  assign break_req = i_break;
`else
  logic unused_break;
  assign unused_break = i_break;
  assign break_req    = 1'b0;
`endif

  assign idle     = (state == ST_IDLE);
  assign o_ready  = idle && !break_req;
  assign transfer = i_valid && o_ready;
  assign tick_end = i_tick && (tick_cnt == NB_TICK_COUNTER'(N_TICKS - 1));
  // The second stop bit reuses the bit counter as a stop-bit index.
  assign stop_end = (state == ST_STOP) && tick_end && (!stop2 || bit_cnt != '0);

  assign o_busy = !idle;
  assign o_done = stop_end;
  assign o_tx   = tx_q;

  // o_tx is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state register.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments; later assignments in
    // this block intentionally override the generic tick-counter update.
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      last_bit  <= '0;
      shift_reg <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      if (!idle && i_tick) begin
        tick_cnt <= tick_end ? '0 : tick_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          tx_q <= !break_req;
          if (transfer) begin
            state     <= ST_START;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= i_data;
            last_bit  <= nb_last[NB_BIT_COUNTER-1:0];
            par_en    <= (i_parity == PAR_EVEN) || (i_parity == PAR_ODD);
            par_bit   <= par_calc;
            stop2     <= i_stop2;
            tx_q      <= 1'b0;
          end
        end

        ST_START: begin
          if (tick_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            tx_q    <= shift_reg[0];
          end
        end

        ST_DATA: begin
          if (tick_end) begin
            if (bit_cnt == last_bit) begin
              bit_cnt <= '0;
              if (par_en) begin
                state <= ST_PARITY;
                tx_q  <= par_bit;
              end else begin
                state <= ST_STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx_q      <= shift_reg[1];
            end
          end
        end

        ST_PARITY: begin
          if (tick_end) begin
            state   <= ST_STOP;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
          end
        end

        ST_STOP: begin
          tx_q <= 1'b1;
          if (stop_end) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else if (tick_end) begin
            bit_cnt <= NB_BIT_COUNTER'(1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frames are described as '0'/'1' strings
// (start, data LSB first, parity, stop bits) and checked tick by tick.
module tb_uart_tx_cfg;

  localparam int N_TICKS  = 16;
  localparam int TICK_DIV = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       i_tick    = 1'b0;
  logic [7:0] i_data    = '0;
  logic       i_valid   = 1'b0;
  logic [3:0] i_nb_data = 4'd8;
  logic [1:0] i_parity  = 2'b00;
  logic       i_stop2   = 1'b0;
  logic       i_break   = 1'b0;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  int tests      = 0;
  int fails      = 0;
  int done_count = 0;
  int tick_div   = 0;
  int done_before;
  int ticks_seen;
  logic brk_tx_seen;
  logic brk_rdy_seen;
  logic brk_busy_seen;

  uart_tx_cfg dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_tick    (i_tick),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_nb_data (i_nb_data),
    .i_parity  (i_parity),
    .i_stop2   (i_stop2),
    .i_break   (i_break),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  // One-clock tick every TICK_DIV clocks, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_div = (tick_div + 1) % TICK_DIV;
      i_tick   = (tick_div == 0);
    end
  end

  always @(negedge clk) if (o_done === 1'b1) done_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a word and returns at the falling edge right after it was accepted.
  task automatic send(input logic [7:0] data, input logic [3:0] nb, input logic [1:0] par,
                      input logic stop2, input bit hold);
    int cyc;
    cyc = 0;
    @(negedge clk);
    i_data    = data;
    i_nb_data = nb;
    i_parity  = par;
    i_stop2   = stop2;
    i_valid   = 1'b1;
    while (o_ready !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) check("send timeout", cyc, 0);
    @(negedge clk);
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input string exp);
    int   b, t, cyc, dones, budget;
    logic exp_bit, seen, ready_seen, done_bad;
    b          = 0;
    t          = 0;
    cyc        = 0;
    dones      = 0;
    budget     = exp.len() * N_TICKS * TICK_DIV + 50;
    seen       = (exp[0] == "1");
    ready_seen = 1'b0;
    done_bad   = 1'b0;
    forever begin
      exp_bit = (exp[b] == "1");
      if (o_tx !== exp_bit) seen = o_tx;
      if (o_ready !== 1'b0 || o_busy !== 1'b1) ready_seen = 1'b1;
      if (o_done === 1'b1) dones++;
      if (o_done !== ((b == exp.len() - 1) && (t == N_TICKS - 1) && i_tick)) done_bad = 1'b1;
      if (i_tick) begin
        t++;
        if (t == N_TICKS) begin
          check($sformatf("%s bit%0d", tag, b), seen, exp_bit);
          t = 0;
          b++;
          if (b < exp.len()) seen = (exp[b] == "1");
        end
      end
      if (b >= exp.len()) break;
      cyc++;
      if (cyc > budget) begin
        check({tag, " timeout"}, b, exp.len());
        break;
      end
      @(negedge clk);
    end
    check({tag, " done pulses"}, dones, 1);
    check({tag, " done timing"}, done_bad, 0);
    check({tag, " ready/busy in frame"}, ready_seen, 0);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, " idle ready"}, o_ready, 1);
    check({tag, " idle busy"}, o_busy, 0);
    check({tag, " idle tx"}, o_tx, 1);
  endtask

  task automatic wait_ticks(input int n);
    int seen, cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < n * TICK_DIV + 20) begin
      @(negedge clk);
      if (i_tick) seen++;
      cyc++;
    end
    check("wait_ticks budget", seen, n);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", o_tx, 1);
    check("reset ready", o_ready, 1);
    check("reset busy", o_busy, 0);
    check("reset done", o_done, 0);
    rst_n = 1'b1;

    // 8N1 0xA5
    send(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0);
    check_frame("8N1_A5", "0101001011");
    check_idle("8N1_A5");

    // 7E2 0x41: two set bits give even parity 0
    send(8'h41, 4'd7, 2'b01, 1'b1, 1'b0);
    check_frame("7E2_41", "01000001011");
    check_idle("7E2_41");

    // 5O1 with all ones: five set bits, odd parity 0, upper bits masked
    send(8'hFF, 4'd5, 2'b10, 1'b0, 1'b0);
    check_frame("5O1_1F", "01111101");
    check_idle("5O1_1F");

    // Out-of-range widths clamp to 8; parity code 11 behaves as none
    send(8'h81, 4'd3, 2'b11, 1'b0, 1'b0);
    check_frame("clamp_lo", "0100000011");
    check_idle("clamp_lo");
    send(8'h81, 4'd12, 2'b01, 1'b0, 1'b0);
    check_frame("clamp_hi", "01000000101");
    check_idle("clamp_hi");

    // Back-to-back: config changed right after the first accept
    send(8'h00, 4'd8, 2'b00, 1'b0, 1'b1);
    i_data    = 8'hFF;
    i_nb_data = 4'd6;
    check_frame("b2b_00", "0000000001");
    check_idle("b2b_gap");
    @(negedge clk);
    i_valid = 1'b0;
    check_frame("b2b_FF", "01111111");
    check_idle("b2b_FF");

    // Reset in the middle of data bit 3
    send(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0);
    wait_ticks(N_TICKS + 3 * N_TICKS + 8);
    check("mid-frame busy", o_busy, 1);
    done_before = done_count;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst mid tx", o_tx, 1);
    check("rst mid ready", o_ready, 1);
    check("rst mid busy", o_busy, 0);
    rst_n = 1'b1;
    wait_ticks(20);
    check("rst mid no done", done_count, done_before);
    check("rst mid line idle", o_tx, 1);
    send(8'h3C, 4'd8, 2'b00, 1'b0, 1'b0);
    check_frame("after_rst", "0001111001");
    check_idle("after_rst");

    // Break request in IDLE
    @(negedge clk);
    i_break       = 1'b1;
    i_valid       = 1'b1;
    i_data        = 8'h55;
    i_nb_data     = 4'd8;
    i_parity      = 2'b00;
    i_stop2       = 1'b0;
    brk_tx_seen   = 1'b0;
    brk_rdy_seen  = 1'b0;
    brk_busy_seen = 1'b0;
    ticks_seen    = 0;
`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    while (ticks_seen < 100) begin
      if (o_tx !== 1'b0) brk_tx_seen = 1'b1;
      if (o_ready !== 1'b0) brk_rdy_seen = 1'b1;
      if (o_busy !== 1'b0) brk_busy_seen = 1'b1;
      if (i_tick) ticks_seen++;
      @(negedge clk);
    end
    check("break tx low", brk_tx_seen, 0);
    check("break ready low", brk_rdy_seen, 0);
    check("break no accept", brk_busy_seen, 0);
    i_break = 1'b0;
    i_valid = 1'b0;
    check_idle("break release");
`else
    i_valid = 1'b0;
    @(negedge clk);
    while (ticks_seen < 20) begin
      if (o_tx !== 1'b1) brk_tx_seen = 1'b1;
      if (o_ready !== 1'b1) brk_rdy_seen = 1'b1;
      if (o_busy !== 1'b0) brk_busy_seen = 1'b1;
      if (i_tick) ticks_seen++;
      @(negedge clk);
    end
    check("break ignored tx", brk_tx_seen, 0);
    check("break ignored ready", brk_rdy_seen, 0);
    check("break ignored busy", brk_busy_seen, 0);
    i_break = 1'b0;
    check_idle("break ignored");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Frame format is configurable at run time: 5..NB_DATA_MAX data bits, none/even/odd parity, 1 or 2 stop bits. Upstream connects through a valid/ready handshake. Bit timing comes from an external oversampling tick strobe supplied by the shared baud-rate generator, and the block drives the serial TX pin.

Parameters:
NB_DATA_MAX, 8, widest data word supported (5..9)
N_TICKS, 16, oversampling ticks per bit
NB_TICK_COUNTER, $clog2(N_TICKS), tick counter width
NB_BIT_COUNTER, $clog2(NB_DATA_MAX), data bit counter width

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset_n  in  1  synchronous active-low reset
i_tick  in  1  single-cycle oversampling strobe, N_TICKS per bit period
i_data  in  NB_DATA_MAX  word to send, LSB first; bits above i_nb_data ignored
i_valid  in  1  upstream word valid
o_ready  out  1  block can accept a word this cycle
i_nb_data  in  4  data bits per frame, 5..NB_DATA_MAX
i_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
i_stop2  in  1  0 one stop bit, 1 two stop bits
i_break  in  1  break request (see Optional Feature)
o_tx  out  1  serial line, idle high, registered
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (i_reset_n=0 at a clock edge): state IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0, all counters 0. Reset mid-frame aborts the frame; o_tx returns high on the next edge.
- Handshake: transfer occurs when i_valid && o_ready. o_ready=1 only in IDLE. i_data, i_nb_data, i_parity and i_stop2 are latched at the transfer. Config changes during a frame have no effect.
- States are one-hot: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_tx=1. On transfer go to START, tick counter=0. o_tx goes low on the edge following the transfer cycle, so latency is 1 clock.
  - START: o_tx=0 for N_TICKS ticks, then go to DATA with bit counter=0.
  - DATA: o_tx = shift_reg[0]. Each bit lasts N_TICKS ticks, then shift right. After bit i_nb_data-1, go to PARITY if parity is enabled, else to STOP.
  - PARITY: even mode sends XOR of the active data bits; odd mode sends its inverse. The parity bit lasts N_TICKS ticks, then go to STOP.
  - STOP: o_tx=1 for N_TICKS ticks, or 2*N_TICKS ticks when i_stop2 is set. On completion, pulse o_done and go to IDLE.
- o_ready rises in the cycle after o_done. Back-to-back frames have no extra idle bits beyond that one clock.
- Counting: the tick counter advances only on i_tick. It compares with N_TICKS-1 and wraps to 0. With no ticks, the state holds indefinitely.
- An i_tick coincident with the transfer cycle is not counted toward START.
- o_busy = !IDLE.
- Parity is computed over the latched word with bits at or above nb_data masked to 0.
- An out-of-range i_nb_data (<5 or >NB_DATA_MAX) is clamped to NB_DATA_MAX at latch.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: while i_break=1 and state is IDLE, o_tx=0 and o_ready=0. Release returns o_tx high on the next edge and restores o_ready. A break request during a frame is ignored until the frame reaches IDLE.
- Undefined: i_break is ignored and no break logic is synthesised.

Decomposition:
- Package uart_pkg holds:
  - state encodings (IDLE..STOP, one-hot, N_STATES=5)
  - parity mode codes PAR_NONE, PAR_EVEN, PAR_ODD
  - default N_TICKS=16
- The package is shared with the matching receiver.
- One natural sub-module, uart_parity_gen: combinational masked XOR with an odd/even select, reused by the receiver for checking.

Test Plan:
- 8N1, i_data=8'hA5, i_tick every 4 clocks -> o_tx: 0, 1,0,1,0,0,1,0,1, 1; each bit exactly 16 ticks; o_done pulses once; o_ready=1 one clock later.
- 7E2, i_data=7'h41 -> data bits 1,0,0,0,0,0,1, parity 0, stop high for 32 ticks.
- 5O1, i_data=5'h1F (i_data upper bits=1) -> five 1s, parity 0, upper bits never appear on o_tx.
- Two words held valid back-to-back (8'h00, 8'hFF) -> second START begins 1 clock after first o_done; i_nb_data changed mid-frame does not alter the first frame.
- Reset asserted low during DATA bit 3 -> next edge o_tx=1, o_ready=1, o_busy=0; no o_done; the following frame is transmitted intact.
- With UART_TX_BREAK_EN, i_break=1 for 100 ticks in IDLE -> o_tx=0 and o_ready=0 throughout; i_valid is not accepted; line is high one clock after release.
